// File: rtl/draw_sprite_if.sv
// rtl/draw_sprite_if.sv - sprite image ROM port: address out, pixel data back
interface draw_sprite_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] pixel_addr;
  logic [11:0]       rgb_pixel;

  modport master (output pixel_addr, input rgb_pixel);
  modport slave  (input pixel_addr, output rgb_pixel);
endinterface

// File: rtl/draw_sprite.sv
// rtl/draw_sprite.sv - 2-stage sprite overlay on a VGA pixel stream
// Sprite position is captured on the vsync rising edge so a frame never tears.
module draw_sprite #(
  parameter int          SPRITE_W  = 64,
  parameter int          SPRITE_H  = 64,
  parameter int          ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  draw_sprite_if.master rom_if
);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vid_t;

  logic [10:0]       x_l_q, x_l_d, y_l_q, y_l_d;
  logic              vs_prev_q, vs_prev_d;
  vid_t              s1_q, s1_d, s2_q, s2_d;
  logic              in_box_q, in_box_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       h12, v12, xl12, yl12;
  logic [10:0]       dx, dy;

  always_comb begin
    x_l_d     = x_l_q;
    y_l_d     = y_l_q;
    vs_prev_d = vsync_in;
    if (vsync_in && !vs_prev_q) begin
      x_l_d = xpos;
      y_l_d = ypos;
    end

    s1_d = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
             vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    // 12-bit bounds so a sprite near column 2047 cannot wrap to the left edge
    h12  = {1'b0, hcount_in};
    v12  = {1'b0, vcount_in};
    xl12 = {1'b0, x_l_q};
    yl12 = {1'b0, y_l_q};
    in_box_d = (h12 >= xl12) && (h12 < xl12 + 12'(SPRITE_W)) &&
               (v12 >= yl12) && (v12 < yl12 + 12'(SPRITE_H));
    dx     = hcount_in - x_l_q;
    dy     = vcount_in - y_l_q;
    addr_d = in_box_d ? ADDR_W'({dy[YW-1:0], dx[XW-1:0]}) : '0;

    s2_d = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) begin
      s2_d.rgb = '0;
    end else if (in_box_q && (rom_if.rgb_pixel != KEY_COLOR)) begin
      s2_d.rgb = rom_if.rgb_pixel;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      x_l_q     <= '0;
      y_l_q     <= '0;
      vs_prev_q <= 1'b0;
      s1_q      <= '0;
      in_box_q  <= 1'b0;
      addr_q    <= '0;
      s2_q      <= '0;
    end else begin
      x_l_q     <= x_l_d;
      y_l_q     <= y_l_d;
      vs_prev_q <= vs_prev_d;
      s1_q      <= s1_d;
      in_box_q  <= in_box_d;
      addr_q    <= addr_d;
      s2_q      <= s2_d;
    end
  end

  assign rom_if.pixel_addr = addr_q;
  assign hcount_out        = s2_q.hcount;
  assign vcount_out        = s2_q.vcount;
  assign hsync_out         = s2_q.hsync;
  assign vsync_out         = s2_q.vsync;
  assign hblnk_out         = s2_q.hblnk;
  assign vblnk_out         = s2_q.vblnk;
  assign rgb_out           = s2_q.rgb;
endmodule

// File: tb/tb_draw_sprite.sv
// tb/tb_draw_sprite.sv - directed table plus randomized model check of draw_sprite
module tb_draw_sprite;
  localparam int          SW  = 64;
  localparam int          SH  = 64;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0, xpos = '0, ypos = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [11:0] rom [0:4095];

  draw_sprite_if #(.ADDR_W(12)) rif ();
  assign rif.rgb_pixel = rom[rif.pixel_addr];

  draw_sprite #(.SPRITE_W(SW), .SPRITE_H(SH), .ADDR_W(12), .KEY_COLOR(KEY)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .rom_if(rif)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int hc, vc; bit hs, vs, hb, vb; int rgb, xp, yp;
  } in_t;
  typedef struct {
    int hc, vc; bit hs, vs, hb, vb; int rgb, addr, tab_rgb, tab_addr;
  } exp_t;
  typedef struct {
    int hc, vc; bit vs, hb, vb; int xp, yp, er, ea;
  } vec_t;

  exp_t q[$];
  int   mxl, myl;
  bit   mvs;
  int   errors = 0;
  int   checks = 0;
  vec_t tab [23];

  task automatic model_reset();
    exp_t z;
    z = '{default: 0};
    z.tab_rgb  = -1;
    z.tab_addr = -1;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    mxl = 0; myl = 0; mvs = 1'b0;
  endtask

  task automatic check_outputs();
    exp_t e;
    logic [37:0] act, req;
    e   = q.pop_front();
    act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    req = {11'(e.hc), 11'(e.vc), e.hs, e.vs, e.hb, e.vb, 12'(e.rgb)};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL stream_out: got %h required %h (hc=%0d vc=%0d)", act, req, e.hc, e.vc);
    end
    if (e.tab_rgb >= 0) begin
      checks++;
      if (rgb_out !== 12'(e.tab_rgb)) begin
        errors++;
        $display("FAIL table_rgb (%0d,%0d): got %h required %h", e.hc, e.vc, rgb_out, 12'(e.tab_rgb));
      end
    end
    checks++;
    if (rif.pixel_addr !== 12'(q[0].addr)) begin
      errors++;
      $display("FAIL pixel_addr: got %0d required %0d", rif.pixel_addr, q[0].addr);
    end
    if (q[0].tab_addr >= 0) begin
      checks++;
      if (rif.pixel_addr !== 12'(q[0].tab_addr)) begin
        errors++;
        $display("FAIL table_addr: got %0d required %0d", rif.pixel_addr, q[0].tab_addr);
      end
    end
  endtask

  // Called at a falling edge: check what is due, drive v, predict its result.
  task automatic step(input in_t v, input int tab_rgb, input int tab_addr);
    exp_t e;
    int dx, dy;
    bit inb;
    logic [11:0] p;
    check_outputs();
    hcount_in = 11'(v.hc); vcount_in = 11'(v.vc);
    hsync_in = v.hs; vsync_in = v.vs; hblnk_in = v.hb; vblnk_in = v.vb;
    rgb_in = 12'(v.rgb); xpos = 11'(v.xp); ypos = 11'(v.yp);
    dx  = v.hc - mxl;
    dy  = v.vc - myl;
    inb = (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
    e.addr = inb ? dy * SW + dx : 0;
    p = rom[e.addr];
    if (v.hb || v.vb) e.rgb = 0;
    else if (inb && p != KEY) e.rgb = int'(p);
    else e.rgb = v.rgb;
    e.hc = v.hc; e.vc = v.vc; e.hs = v.hs; e.vs = v.vs; e.hb = v.hb; e.vb = v.vb;
    e.tab_rgb = tab_rgb; e.tab_addr = tab_addr;
    q.push_back(e);
    if (v.vs && !mvs) begin
      mxl = v.xp; myl = v.yp;
    end
    mvs = v.vs;
    @(negedge pclk);
  endtask

  task automatic rand_inputs();
    hcount_in = 11'($urandom); vcount_in = 11'($urandom);
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
    rgb_in = 12'($urandom); xpos = 11'($urandom); ypos = 11'($urandom);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
         rgb_out, rif.pixel_addr} !== '0) begin
      errors++;
      $display("FAIL %s: outputs %h rgb %h addr %0d required all 0", nm,
               {hcount_out, vcount_out}, rgb_out, rif.pixel_addr);
    end
  endtask

  function automatic in_t rand_vec();
    in_t v;
    int r;
    r = $urandom_range(0, SW + 16) - 8;
    v.hc = ($urandom % 2 == 0) ? $urandom_range(0, 1343) : ((mxl + r < 0) ? 0 : mxl + r);
    r = $urandom_range(0, SH + 16) - 8;
    v.vc = ($urandom % 2 == 0) ? $urandom_range(0, 805) : ((myl + r < 0) ? 0 : myl + r);
    if (v.hc > 2047) v.hc = 2047;
    if (v.vc > 2047) v.vc = 2047;
    v.hb  = (v.hc >= 1024);
    v.vb  = (v.vc >= 768);
    v.hs  = 1'($urandom);
    v.vs  = ($urandom % 40 == 0);
    v.rgb = int'(12'($urandom));
    v.xp  = $urandom_range(0, 1100);
    v.yp  = $urandom_range(0, 800);
    return v;
  endfunction

  initial begin
    in_t v;
    for (int i = 0; i < 4096; i++) rom[i] = 12'h0F0;
    rom[5 * SW + 7] = KEY;

    //          hc    vc   vs hb vb  xp    yp   rgb     addr
    tab[0]  = '{0,    0,   1, 0, 1, 100,  200, 0,      -1};
    tab[1]  = '{0,    0,   0, 0, 1, 100,  200, 0,      -1};
    tab[2]  = '{100,  200, 0, 0, 0, 100,  200, 'h0F0,  0};
    tab[3]  = '{163,  263, 0, 0, 0, 100,  200, 'h0F0,  4095};
    tab[4]  = '{99,   200, 0, 0, 0, 100,  200, 'h00F,  0};
    tab[5]  = '{164,  200, 0, 0, 0, 100,  200, 'h00F,  0};
    tab[6]  = '{100,  264, 0, 0, 0, 100,  200, 'h00F,  0};
    tab[7]  = '{107,  205, 0, 0, 0, 100,  200, 'h00F,  327};
    tab[8]  = '{130,  210, 0, 0, 0, 100,  200, 'h0F0,  670};
    tab[9]  = '{100,  210, 0, 0, 0, 500,  200, 'h0F0,  -1};
    tab[10] = '{500,  210, 0, 0, 0, 500,  200, 'h00F,  0};
    tab[11] = '{0,    0,   1, 0, 1, 500,  200, 0,      -1};
    tab[12] = '{0,    0,   0, 0, 1, 500,  200, 0,      -1};
    tab[13] = '{500,  210, 0, 0, 0, 500,  200, 'h0F0,  640};
    tab[14] = '{100,  210, 0, 0, 0, 500,  200, 'h00F,  0};
    tab[15] = '{0,    0,   1, 0, 1, 1000, 200, 0,      -1};
    tab[16] = '{0,    0,   0, 0, 1, 1000, 200, 0,      -1};
    tab[17] = '{1000, 210, 0, 0, 0, 1000, 200, 'h0F0,  640};
    tab[18] = '{1023, 210, 0, 0, 0, 1000, 200, 'h0F0,  663};
    tab[19] = '{1024, 210, 0, 1, 0, 1000, 200, 0,      -1};
    tab[20] = '{1063, 210, 0, 1, 0, 1000, 200, 0,      -1};
    tab[21] = '{0,    210, 0, 0, 0, 1000, 200, 'h00F,  0};
    tab[22] = '{39,   210, 0, 0, 0, 1000, 200, 'h00F,  0};

    // Reset held with live stimulus: every output stays at zero
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check_zero("reset_hold");
      rand_inputs();
    end
    @(negedge pclk);
    rst = 1'b1;
    model_reset();

    foreach (tab[i]) begin
      v = '{hc: tab[i].hc, vc: tab[i].vc, hs: 1'b0, vs: tab[i].vs, hb: tab[i].hb,
            vb: tab[i].vb, rgb: 'h00F, xp: tab[i].xp, yp: tab[i].yp};
      step(v, tab[i].er, tab[i].ea);
    end
    v = '{hc: 1100, vc: 780, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1, rgb: 'h00F, xp: 0, yp: 0};
    step(v, -1, -1);
    step(v, -1, -1);

    // Random sprite contents loaded while the block sits in reset
    #2 rst = 1'b0;
    for (int i = 0; i < 4096; i++) rom[i] = ($urandom % 4 == 0) ? KEY : 12'($urandom);
    @(negedge pclk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) step(rand_vec(), -1, -1);

    // Asynchronous reset mid-frame, then refill with no stale sprite data
    #2 rst = 1'b0;
    #1 check_zero("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check_zero("reset_mid_frame");
      rand_inputs();
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) step(rand_vec(), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
